// File: rtl/pe_acc_pkg.sv
// Shared types for the PE accumulation stage.
// Precision encodings (also used by the adder), FSM states, requant config.
package pe_acc_pkg;

  typedef logic [2:0] prec_t;

  localparam prec_t PREC_8B = 3'b100;
  localparam prec_t PREC_4B = 3'b010;
  localparam prec_t PREC_2B = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  typedef struct packed {
    prec_t      prec;
    logic [4:0] shift;
    logic       relu;
  } rq_cfg_t;

  // Beats-per-group with 0 promoted to 1.
  function automatic logic [15:0] eff_num16(input logic [15:0] n);
    return (n == '0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/acc_requant.sv
// Requantizer: ACC_DATA_WIDTH sum -> ACT_DATA_WIDTH activation.
// Ports: sum_i, cfg_i (prec/shift/relu) -> data_o; 8b mode shifts/relus/saturates.
module acc_requant
  import pe_acc_pkg::*;
#(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int ACT_DATA_WIDTH = 8
) (
  input  logic [ACC_DATA_WIDTH-1:0] sum_i,
  input  rq_cfg_t                   cfg_i,
  output logic [ACT_DATA_WIDTH-1:0] data_o
);

  localparam logic signed [ACC_DATA_WIDTH-1:0] SAT_MAX =
    ACC_DATA_WIDTH'((64'd1 << (ACT_DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [ACC_DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_DATA_WIDTH-1:0] shifted;
  logic signed [ACC_DATA_WIDTH-1:0] clamped;
  logic signed [ACC_DATA_WIDTH-1:0] sat;

  always_comb begin
    shifted = $signed(sum_i) >>> cfg_i.shift;
    clamped = shifted;
    if (cfg_i.relu && shifted[ACC_DATA_WIDTH-1]) begin
      clamped = '0;
    end
    sat = clamped;
    if (clamped > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (clamped < SAT_MIN) begin
      sat = SAT_MIN;
    end
  end

  // Packed 4b/2b lanes were already wrapped by the adder: pass through.
  always_comb begin
    data_o = sum_i[ACT_DATA_WIDTH-1:0];
    unique case (1'b1)
      (cfg_i.prec == PREC_8B): data_o = sat[ACT_DATA_WIDTH-1:0];
      default:                 data_o = sum_i[ACT_DATA_WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/pe_accumulator.sv
// PE accumulation stage: feeds running sum to the adder, counts beats,
// emits requantized result on out_valid/out_ready. Config shadowed per group.
module pe_accumulator
  import pe_acc_pkg::*;
#(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [2:0]                mode_precision_layer,
  input  logic [CNT_WIDTH-1:0]      cfg_num_acc,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ACC_DATA_WIDTH-1:0] acc_partial,
  input  logic [ACC_DATA_WIDTH-1:0] adder_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACT_DATA_WIDTH-1:0] out_data,
  output logic                      busy
);

  acc_state_e                state_q;
  logic [CNT_WIDTH-1:0]      count_q;
  logic [ACC_DATA_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0]      num_q;
  rq_cfg_t                   cfg_q;
  logic [ACT_DATA_WIDTH-1:0] data_q;

  logic                      first;
  logic [CNT_WIDTH-1:0]      num_d;
  rq_cfg_t                   cfg_live;
  rq_cfg_t                   cfg_d;
  logic [CNT_WIDTH:0]        count_d;
  logic                      last;
  logic                      accept;
  logic [ACT_DATA_WIDTH-1:0] data_d;

  // First beat of a group uses live config; later beats use the shadow.
  always_comb begin
    first          = (count_q == '0);
    cfg_live.prec  = mode_precision_layer;
    cfg_live.shift = cfg_shift;
    cfg_live.relu  = cfg_relu;
    num_d          = (cfg_num_acc == '0)
                   ? CNT_WIDTH'(1) : cfg_num_acc;
    if (!first) begin
      num_d = num_q;
    end
    cfg_d   = first ? cfg_live : cfg_q;
    count_d = {1'b0, count_q} + 1'b1;
    last    = (count_d == {1'b0, num_d});
  end

  assign in_ready    = (state_q != DRAIN) | out_ready;
  assign accept      = in_valid & in_ready;
  assign acc_partial = first ? '0 : acc_q;
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
  assign out_data    = data_q;

  acc_requant #(
    .ACC_DATA_WIDTH(ACC_DATA_WIDTH),
    .ACT_DATA_WIDTH(ACT_DATA_WIDTH)
  ) u_requant (
    .sum_i (adder_sum),
    .cfg_i (cfg_d),
    .data_o(data_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      cfg_q   <= '0;
      data_q  <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
    end else if (accept) begin
      acc_q <= adder_sum;
      if (first) begin
        num_q <= num_d;
        cfg_q <= cfg_live;
      end
      if (last) begin
        count_q <= '0;
        state_q <= DRAIN;
        data_q  <= data_d;
      end else begin
        count_q <= count_d[CNT_WIDTH-1:0];
        state_q <= ACCUM;
      end
    end else if (state_q == DRAIN && out_ready) begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: directed plan cases plus random traffic
// against a group-level reference model.
module tb_pe_accumulator;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [2:0]  mode_precision_layer;
  logic [15:0] cfg_num_acc;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] acc_partial;
  logic [31:0] adder_sum;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic [31:0] beat;

  int n_cmp = 0;
  int n_err = 0;

  int         m_cnt;
  longint     m_sum;
  int         m_num;
  int         m_shift;
  bit         m_relu;
  logic [2:0] m_prec;
  bit         m_pend;
  logic [7:0] m_out;

  assign adder_sum = acc_partial + beat;

  pe_accumulator dut (
    .clk                 (clk),
    .reset               (reset),
    .clear               (clear),
    .mode_precision_layer(mode_precision_layer),
    .cfg_num_acc         (cfg_num_acc),
    .cfg_shift           (cfg_shift),
    .cfg_relu            (cfg_relu),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .acc_partial         (acc_partial),
    .adder_sum           (adder_sum),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Floor division by 2^sh, then relu and clamp to int8.
  function automatic logic [7:0] ref_rq(longint s, int sh, bit relu,
                                        logic [2:0] prec);
    longint d;
    longint y;
    logic [7:0] r;
    if (prec != 3'b100) begin
      r = s[7:0];
      return r;
    end
    d = 1;
    repeat (sh) d = d * 2;
    if (s >= 0) y = s / d;
    else        y = -((-s + d - 1) / d);
    if (relu && y < 0) y = 0;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    r = y[7:0];
    return r;
  endfunction

  task automatic check_outputs();
    logic [31:0] ep;
    ep = (m_cnt == 0) ? 32'd0 : 32'(m_sum);
    chk("acc_partial", {32'd0, acc_partial}, {32'd0, ep});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_pend || out_ready)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_pend});
    chk("busy", {63'd0, busy}, {63'd0, (m_pend || m_cnt != 0)});
    if (m_pend) chk("out_data", {56'd0, out_data}, {56'd0, m_out});
  endtask

  task automatic model_edge();
    bit rdy;
    if (clear) begin
      m_cnt = 0;
      m_sum = 0;
      m_pend = 0;
      return;
    end
    rdy = !m_pend || out_ready;
    if (m_pend && out_ready) m_pend = 0;
    if (in_valid && rdy) begin
      if (m_cnt == 0) begin
        m_num   = (cfg_num_acc == 0) ? 1 : int'(cfg_num_acc);
        m_shift = int'(cfg_shift);
        m_relu  = cfg_relu;
        m_prec  = mode_precision_layer;
        m_sum   = 0;
      end
      m_sum = m_sum + longint'($signed(beat));
      m_cnt++;
      if (m_cnt == m_num) begin
        m_out  = ref_rq(m_sum, m_shift, m_relu, m_prec);
        m_pend = 1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic step(bit v, int b, bit ordy, bit clr);
    in_valid  = v;
    beat      = 32'(b);
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rst_acc_partial", {32'd0, acc_partial}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_data", {56'd0, out_data}, 64'd0);
    m_cnt = 0;
    m_sum = 0;
    m_pend = 0;
    m_out = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(logic [2:0] p, int n, int sh, bit r);
    mode_precision_layer = p;
    cfg_num_acc = 16'(n);
    cfg_shift   = 5'(sh);
    cfg_relu    = r;
  endtask

  initial begin
    beat = 32'd0;
    out_ready = 1'b1;
    m_num = 1;
    m_shift = 0;
    m_relu = 0;
    m_prec = 3'b100;
    set_cfg(3'b100, 4, 0, 0);
    do_reset();

    step(1, 10, 1, 0);
    step(1, 20, 1, 0);
    step(1, 30, 1, 0);
    step(1, 40, 1, 0);
    chk("plan_sum100", {56'd0, out_data}, 64'd100);
    chk("plan_valid", {63'd0, out_valid}, 64'd1);
    step(0, 0, 1, 0);

    set_cfg(3'b100, 2, 0, 0);
    step(1, 100, 1, 0);
    step(1, 100, 1, 0);
    chk("sat_pos", {56'd0, out_data}, 64'h7f);
    step(1, -200, 1, 0);
    step(1, -100, 1, 0);
    chk("sat_neg", {56'd0, out_data}, 64'h80);
    set_cfg(3'b100, 1, 0, 1);
    step(1, -5, 1, 0);
    chk("relu", {56'd0, out_data}, 64'h00);

    set_cfg(3'b100, 1, 3, 0);
    step(1, 1000, 1, 0);
    chk("shift3", {56'd0, out_data}, 64'd125);
    set_cfg(3'b100, 1, 1, 0);
    step(1, -9, 1, 0);
    chk("shift_neg", {56'd0, out_data}, 64'hfb);
    step(0, 0, 1, 0);

    set_cfg(3'b100, 1, 0, 0);
    step(1, 7, 1, 0);
    repeat (5) step(1, 50, 0, 0);
    chk("bp_hold", {56'd0, out_data}, 64'd7);
    step(1, 9, 1, 0);
    chk("bp_next", {56'd0, out_data}, 64'd9);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    step(0, 0, 1, 0);

    set_cfg(3'b010, 1, 0, 0);
    step(1, 165, 1, 0);
    chk("b4_pass", {56'd0, out_data}, 64'ha5);
    step(0, 0, 1, 0);
    set_cfg(3'b100, 2, 0, 0);
    step(1, 100, 1, 0);
    set_cfg(3'b010, 1, 2, 0);
    step(1, 100, 1, 0);
    chk("midgrp_cfg", {56'd0, out_data}, 64'h7f);
    step(1, 200, 1, 0);
    chk("next_grp_cfg", {56'd0, out_data}, 64'hc8);
    step(0, 0, 1, 0);

    set_cfg(3'b100, 4, 0, 0);
    step(1, 11, 1, 0);
    step(1, 12, 1, 0);
    do_reset();

    set_cfg(3'b100, 1, 0, 0);
    step(1, 3, 1, 0);
    step(1, 5, 1, 1);
    chk("clr_valid", {63'd0, out_valid}, 64'd0);
    chk("clr_busy", {63'd0, busy}, 64'd0);
    step(0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0: mode_precision_layer = 3'b100;
          1: mode_precision_layer = 3'b010;
          default: mode_precision_layer = 3'b001;
        endcase
        cfg_num_acc = 16'($urandom_range(4));
        cfg_shift   = 5'($urandom_range(7));
        cfg_relu    = 1'($urandom_range(1));
      end
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(3) != 0),
             int'($urandom_range(600)) - 300,
             1'($urandom_range(3) != 0),
             $urandom_range(63) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_accumulator.md
# pe_accumulator

Sequential accumulation stage of the processing element. It closes the loop around the combinational precision-scalable adder:
- drives the adder's second operand with the running partial sum;
- registers the adder result each accepted beat;
- after a configured number of beats, requantizes the sum to activation width and emits it on a valid/ready output handshake.

It sits between the multiplier/adder pair and the PE output/activation writeback.

## Interface
Parameters:
- ACC_DATA_WIDTH, 32, accumulator and adder operand width
- ACT_DATA_WIDTH, 8, output activation width
- CNT_WIDTH, 16, beat-counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- clear  in  1  synchronous flush of the current group; highest priority after reset
- mode_precision_layer  in  3  100 = 8b, 010 = 4b packed, 001 = 2b packed
- cfg_num_acc  in  CNT_WIDTH  beats per output group; 0 is treated as 1
- cfg_shift  in  5  arithmetic right shift applied before saturation (8b mode only)
- cfg_relu  in  1  clamp negative results to 0 (8b mode only)
- in_valid  in  1  product beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- acc_partial  out  ACC_DATA_WIDTH  operand to the adder's input_1
- adder_sum  in  ACC_DATA_WIDTH  adder output, combinational, same cycle
- out_valid  out  1  requantized result available
- out_ready  in  1  downstream accepts
- out_data  out  ACT_DATA_WIDTH  result
- busy  out  1  state != IDLE

## Operation
- States: IDLE (no beats held), ACCUM (1 ≤ count < num_acc), DRAIN (result held, out_valid = 1).
- Registers: acc_reg, count, shadow copies of all cfg_* and mode inputs, out_data, state.
- Shadow config:
  - Sampled on the first accepted beat of a group (count == 0).
  - Changes to cfg_* or mode mid-group have no effect until the next group.
- acc_partial: 0 when count == 0, otherwise acc_reg. It is a function of registers only; there is no combinational path from in_valid.
- in_ready: 1 in IDLE and ACCUM; in DRAIN it equals out_ready.
- On accept: acc_reg <= adder_sum and count <= count + 1.
- Final beat of a group (count + 1 == num_acc):
  - count <= 0, state <= DRAIN;
  - out_data <= requant(adder_sum).
- Other accepts:
  - IDLE -> ACCUM;
  - ACCUM stays ACCUM.
- DRAIN with out_ready:
  - result is consumed;
  - if in_valid in the same cycle, the beat starts a new group with acc_partial = 0;
  - with num_acc == 1, the next state is DRAIN again, with new data;
  - with no in_valid, the next state is IDLE.
- DRAIN without out_ready: out_data and out_valid are held stable and no beat is accepted.
- requant in 8b mode:
  - y = adder_sum >>> shift (floor);
  - if relu and y < 0, then y = 0;
  - saturate to [-128, 127].
- requant in 4b and 2b modes: out_data = adder_sum[7:0] passed through unchanged. Lanes are already packed and wrapped by the adder; no shift, relu or saturation.
- clear: state <= IDLE, count <= 0, acc_reg <= 0, out_valid <= 0. A beat presented in the same cycle is dropped.
- Reset values: state IDLE, acc_reg 0, count 0, out_data 0, out_valid 0, busy 0, acc_partial 0, in_ready 1.

## Timing
- Throughput: one beat per cycle, including the cycle in which the previous result is handed off (back-to-back groups have no bubble).
- Latency: out_valid rises in the cycle after the final beat's accept edge.
- Combinational path: acc_partial -> adder -> adder_sum -> acc_reg/out_data must close within one cycle.
- Reset asserted mid-group or in DRAIN aborts everything immediately. There is no partial output.
- count wrap: impossible, since count < num_acc ≤ 2^CNT_WIDTH - 1.

## Structure
- Shared package pe_acc_pkg holds:
  - precision encodings PREC_8B = 3'b100, PREC_4B = 3'b010, PREC_2B = 3'b001;
  - state enum {IDLE, ACCUM, DRAIN}.
  - The adder uses the same encodings.
- One sub-module, acc_requant: combinational shift, ReLU and saturate from ACC_DATA_WIDTH to ACT_DATA_WIDTH, with precision bypass.
- Expected size: roughly 150–250 lines.

## Test plan
- 8b, num_acc = 4, shift = 0, adder modelled as a + b; beats 10, 20, 30, 40 -> acc_partial 0, 10, 30, 60; one cycle later out_valid = 1, out_data = 100.
- Saturation:
  - num_acc = 2, beats 100, 100 -> out_data = 127;
  - beats -200, -100 -> -128;
  - relu = 1 with sum -5 -> 0.
- Shift: num_acc = 1, beat 1000 with shift 3 -> 125; beat -9 with shift 1 -> -5.
- Backpressure:
  - out_ready = 0 for 5 cycles -> in_ready = 0, out_data stable;
  - then out_ready = 1 with in_valid = 1 -> both handshakes complete in the same cycle, acc_partial = 0.
- 4b mode: num_acc = 1, adder_sum[7:0] = 0xA5 -> out_data = 0xA5 with no saturation; a cfg change mid-group is ignored until the next group.
- Reset low after 2 of 4 beats -> all outputs return to reset values; clear in DRAIN -> out_valid = 0 next cycle, then IDLE.
